zx_vram_arbiter: RTL and testbench

Shared video-RAM arbiter between the ULA video fetcher and the CPU memory path. It owns the single external 512 KiB SRAM bus: va, vd, n_vrd and n_vwr. Accesses are fixed-length 4-cycle clk28 transactions. Video gets priority, with a fairness rule that bounds CPU starvation. It sits inside zx_ula, between the screen/attribute fetch logic, the CPU bus decoder and the board SRAM pins.

---
 rtl/zx_vram_pkg.sv | 20 ++
 rtl/zx_vram_arbiter.sv | 122 ++++++++++++
 tb/tb_zx_vram_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/zx_vram_pkg.sv
// Shared types and sizes for the ZX video-RAM arbiter.
package zx_vram_pkg;

    localparam int VRAM_AW = 19;
    localparam int VRAM_DW = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE1 = 3'd2,
        STROBE2 = 3'd3,
        HOLD    = 3'd4
    } vram_state_e;

    typedef enum logic {
        OWN_VIDEO = 1'b0,
        OWN_CPU   = 1'b1
    } vram_owner_e;

endpackage

// File: rtl/zx_vram_arbiter.sv
// Single-SRAM arbiter: fixed 4-cycle accesses, video priority with CPU fairness.
// Define VRAM_CPU_WAIT_EN to drive a registered Z80 wait request on cpu_wait.
module zx_vram_arbiter
    import zx_vram_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          clk28,
    input  logic          rst,
    input  logic          video_req,
    input  logic [AW-1:0] video_addr,
    output logic          video_ack,
    output logic [DW-1:0] video_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_wait,
    output logic [AW-1:0] va,
    input  logic [DW-1:0] vd_i,
    output logic [DW-1:0] vd_o,
    output logic          vd_oe,
    output logic          n_vrd,
    output logic          n_vwr
);

    vram_state_e state;
    vram_owner_e owner;
    logic        last_video;
    logic        we_q;

    logic v_cand, c_cand, pick_cpu, pick_video, arb;

    // A requester whose ack is showing this cycle has just been served.
    assign v_cand     = video_req & ~video_ack;
    assign c_cand     = cpu_req & ~cpu_ack;
    assign pick_cpu   = c_cand & (~v_cand | last_video);
    assign pick_video = v_cand & ~pick_cpu;
    assign arb        = (state == IDLE) || (state == HOLD);

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_VIDEO;
            last_video <= 1'b0;
            we_q       <= 1'b0;
            va         <= '0;
            vd_o       <= '0;
            vd_oe      <= 1'b0;
            n_vrd      <= 1'b1;
            n_vwr      <= 1'b1;
            video_ack  <= 1'b0;
            cpu_ack    <= 1'b0;
            video_data <= '0;
            cpu_rdata  <= '0;
        end else begin
            video_ack <= 1'b0;
            cpu_ack   <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    vd_oe <= 1'b0;
                    if (pick_cpu || pick_video) begin
                        state <= SETUP;
                        owner <= pick_cpu ? OWN_CPU : OWN_VIDEO;
                        va    <= pick_cpu ? cpu_addr : video_addr;
                        we_q  <= pick_cpu & cpu_we;
                        vd_oe <= pick_cpu & cpu_we;
                        if (pick_cpu) vd_o <= cpu_wdata;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETUP: begin
                    state <= STROBE1;
                    n_vrd <= we_q;
                    n_vwr <= ~we_q;
                end
                STROBE1: state <= STROBE2;
                STROBE2: begin
                    state      <= HOLD;
                    n_vrd      <= 1'b1;
                    n_vwr      <= 1'b1;
                    last_video <= (owner == OWN_VIDEO);
                    if (owner == OWN_VIDEO) begin
                        video_ack  <= 1'b1;
                        video_data <= vd_i;
                    end else begin
                        cpu_ack <= 1'b1;
                        if (!we_q) cpu_rdata <= vd_i;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VRAM_CPU_WAIT_EN
    logic cpu_busy;
    logic cpu_wait_q;

    // The CPU's own in-flight access must not re-raise wait.
    assign cpu_busy = !arb && (owner == OWN_CPU);

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            cpu_wait_q <= 1'b0;
        end else if (!cpu_req || (arb && pick_cpu)) begin
            cpu_wait_q <= 1'b0;
        end else if (!cpu_ack && !cpu_busy) begin
            cpu_wait_q <= 1'b1;
        end
    end

    assign cpu_wait = cpu_wait_q;
`else
    assign cpu_wait = 1'b0;
`endif

endmodule

// File: tb/tb_zx_vram_arbiter.sv
// Self-checking bench for zx_vram_arbiter with a behavioural SRAM and transaction-level model.
module tb_zx_vram_arbiter;
    import zx_vram_pkg::*;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam logic [AW-1:0] RBASE = 19'h02000;

    logic          clk28 = 1'b0;
    logic          rst = 1'b1;
    logic          video_req = 1'b0;
    logic [AW-1:0] video_addr = '0;
    logic          video_ack;
    logic [DW-1:0] video_data;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_wait;
    logic [AW-1:0] va;
    logic [DW-1:0] vd_i;
    logic [DW-1:0] vd_o;
    logic          vd_oe;
    logic          n_vrd;
    logic          n_vwr;

    int checks = 0;
    int failures = 0;

    zx_vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk28(clk28), .rst(rst),
        .video_req(video_req), .video_addr(video_addr),
        .video_ack(video_ack), .video_data(video_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .cpu_wait(cpu_wait), .va(va), .vd_i(vd_i), .vd_o(vd_o),
        .vd_oe(vd_oe), .n_vrd(n_vrd), .n_vwr(n_vwr)
    );

    always #18 clk28 = ~clk28;

    // Asynchronous SRAM: reads follow va, writes land while n_vwr is low.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    assign vd_i = sram[va];

    always @(posedge clk28) begin
        if (!n_vwr && vd_oe) sram[va] <= vd_o;
        else if (bd_we) sram[bd_addr] <= bd_data;
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        @(negedge clk28);
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        video_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk28);
        rst = 1'b0;
        @(negedge clk28);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk28);
        checks++; if (va !== '0) begin failures++; $display("FAIL rst_va: got %h want 0", va); end
        checks++; if (vd_o !== '0 || vd_oe !== 1'b0) begin failures++; $display("FAIL rst_vd: got vd_o=%h oe=%b want 0/0", vd_o, vd_oe); end
        checks++; if ({n_vrd, n_vwr} !== 2'b11) begin failures++; $display("FAIL rst_strobes: got %b want 11", {n_vrd, n_vwr}); end
        checks++; if ({video_ack, cpu_ack, cpu_wait} !== 3'b000) begin failures++; $display("FAIL rst_acks: got %b want 000", {video_ack, cpu_ack, cpu_wait}); end
        checks++; if (video_data !== '0 || cpu_rdata !== '0) begin failures++; $display("FAIL rst_data: got %h/%h want 00/00", video_data, cpu_rdata); end
        rst = 1'b0;
        @(negedge clk28);
        checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL rst_state: got %0d want IDLE", dut.state); end
    endtask

    task automatic test_video_only();
        int rd_low = 0, wr_low = 0, n_ack = 0, ack_cyc = -1;
        logic [DW-1:0] got = '0;
        preload(19'h1A000, 8'h5C);
        video_addr = 19'h1A000; video_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk28);
            if (!n_vrd) begin
                rd_low++;
                checks++; if (va !== 19'h1A000) begin failures++; $display("FAIL vid_va: got %h want 1a000", va); end
            end
            if (!n_vwr) wr_low++;
            if (video_ack) begin n_ack++; ack_cyc = i; got = video_data; video_req = 1'b0; end
        end
        checks++; if (rd_low != 2) begin failures++; $display("FAIL vid_rd_width: got %0d want 2", rd_low); end
        checks++; if (wr_low != 0) begin failures++; $display("FAIL vid_no_write: got %0d want 0", wr_low); end
        checks++; if (n_ack != 1 || ack_cyc != 4) begin failures++; $display("FAIL vid_ack: got n=%0d cyc=%0d want 1/4", n_ack, ack_cyc); end
        checks++; if (got !== 8'h5C) begin failures++; $display("FAIL vid_data: got %h want 5c", got); end
    endtask

    task automatic test_cpu_write_read();
        int oe_hi = 0, wr_low = 0, rd_low = 0, ack_cyc = -1;
        logic [DW-1:0] got = '0;
        cpu_addr = 19'h04000; cpu_wdata = 8'hA5; cpu_we = 1'b1; cpu_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk28);
            if (vd_oe) oe_hi++;
            if (!n_vwr) wr_low++;
            if (!n_vrd) rd_low++;
            if (cpu_ack) begin ack_cyc = i; cpu_req = 1'b0; end
        end
        checks++; if (oe_hi != 4) begin failures++; $display("FAIL wr_oe_width: got %0d want 4", oe_hi); end
        checks++; if (wr_low != 2 || rd_low != 0) begin failures++; $display("FAIL wr_strobes: got wr=%0d rd=%0d want 2/0", wr_low, rd_low); end
        checks++; if (ack_cyc != 4) begin failures++; $display("FAIL wr_ack: got %0d want 4", ack_cyc); end
        cpu_we = 1'b0; cpu_wdata = 8'h00; cpu_req = 1'b1; ack_cyc = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk28);
            if (cpu_ack) begin ack_cyc = i; got = cpu_rdata; cpu_req = 1'b0; end
        end
        checks++; if (ack_cyc != 4 || got !== 8'hA5) begin failures++; $display("FAIL rd_back: got cyc=%0d data=%h want 4/a5", ack_cyc, got); end
    endtask

    task automatic test_first_simultaneous();
        int v_cyc = -1, c_cyc = -1;
        do_reset();
        video_addr = 19'h1A000; cpu_addr = 19'h04000; cpu_we = 1'b0;
        video_req = 1'b1; cpu_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk28);
            if (video_ack) begin v_cyc = i; video_req = 1'b0; end
            if (cpu_ack) begin c_cyc = i; cpu_req = 1'b0; end
        end
        checks++; if (v_cyc != 4) begin failures++; $display("FAIL sim_video_first: got %0d want 4", v_cyc); end
        checks++; if (c_cyc != 8) begin failures++; $display("FAIL sim_cpu_second: got %0d want 8", c_cyc); end
    endtask

    task automatic test_contention();
        int rd_low = 0, nv = 0, nc = 0, gap = 0;
        int seq[$];
        do_reset();
        video_addr = 19'h1A000; cpu_addr = 19'h04000; cpu_we = 1'b0;
        video_req = 1'b1; cpu_req = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk28);
            if (!n_vrd) rd_low++;
            if (video_ack) begin nv++; seq.push_back(0); if (i % 4 != 0) gap++; end
            if (cpu_ack) begin nc++; seq.push_back(1); if (i % 4 != 0) gap++; end
        end
        video_req = 1'b0; cpu_req = 1'b0;
        repeat (6) @(negedge clk28);
        checks++; if (nv != 4 || nc != 4) begin failures++; $display("FAIL cont_counts: got v=%0d c=%0d want 4/4", nv, nc); end
        checks++; if (gap != 0 || rd_low != 16) begin failures++; $display("FAIL cont_no_idle: got offgrid=%0d rdlow=%0d want 0/16", gap, rd_low); end
        for (int j = 0; j < seq.size(); j++) begin
            checks++; if (seq[j] != j % 2) begin failures++; $display("FAIL cont_order[%0d]: got %0d want %0d", j, seq[j], j % 2); end
        end
    endtask

    task automatic test_cpu_wait();
        int w_cnt = 0, w_first = -1, c_cyc = -1, exp_cnt, exp_first;
`ifdef VRAM_CPU_WAIT_EN
        exp_cnt = 2; exp_first = 3;
`else
        exp_cnt = 0; exp_first = -1;
`endif
        video_addr = 19'h1A001; cpu_addr = 19'h04001; cpu_we = 1'b0;
        video_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk28);
            if (cpu_wait) begin w_cnt++; if (w_first < 0) w_first = i; end
            if (video_ack) video_req = 1'b0;
            if (cpu_ack) begin c_cyc = i; cpu_req = 1'b0; end
            if (i == 2) cpu_req = 1'b1;
        end
        checks++; if (w_cnt != exp_cnt || w_first != exp_first) begin failures++; $display("FAIL cpu_wait: got cnt=%0d first=%0d want %0d/%0d", w_cnt, w_first, exp_cnt, exp_first); end
        checks++; if (c_cyc != 8) begin failures++; $display("FAIL wait_cpu_ack: got %0d want 8", c_cyc); end
    endtask

    task automatic test_reset_mid();
        int n_ack = 0, ack_cyc = -1;
        logic [DW-1:0] got = '0;
        preload(19'h05555, 8'h3C);
        cpu_addr = 19'h05555; cpu_we = 1'b0; cpu_req = 1'b1;
        repeat (2) @(negedge clk28);
        checks++; if (n_vrd !== 1'b0) begin failures++; $display("FAIL abort_pre_strobe: got %b want 0", n_vrd); end
        rst = 1'b1;
        #1;
        checks++; if (n_vrd !== 1'b1 || vd_oe !== 1'b0) begin failures++; $display("FAIL abort_pins: got rd=%b oe=%b want 1/0", n_vrd, vd_oe); end
        checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL abort_state: got %0d want IDLE", dut.state); end
        cpu_req = 1'b0;
        @(negedge clk28);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk28);
            if (cpu_ack) n_ack++;
        end
        checks++; if (n_ack != 0) begin failures++; $display("FAIL abort_no_ack: got %0d want 0", n_ack); end
        cpu_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk28);
            if (cpu_ack) begin ack_cyc = i; got = cpu_rdata; cpu_req = 1'b0; end
        end
        checks++; if (ack_cyc != 4 || got !== 8'h3C) begin failures++; $display("FAIL abort_recover: got cyc=%0d data=%h want 4/3c", ack_cyc, got); end
    endtask

    // Transaction-level model: serialized accesses, latency 4..8, reads see prior writes.
    task automatic test_random();
        logic [DW-1:0] gmem [8];
        int cyc, v_t0 = 0, c_t0 = 0, nv = 0, nc = 0;
        logic v_pend = 1'b0, c_pend = 1'b0, c_we = 1'b0;
        logic [2:0] v_slot = '0, c_slot = '0;
        logic [DW-1:0] c_wd = '0;
        for (int s = 0; s < 8; s++) begin
            gmem[s] = 8'($urandom);
            preload(RBASE + 19'(s), gmem[s]);
        end
        for (cyc = 1; cyc <= 700; cyc++) begin
            @(negedge clk28);
            if (video_ack) begin
                checks++; if (!v_pend || cpu_ack || video_data !== gmem[v_slot]) begin failures++; $display("FAIL rnd_video: got %h want %h cyc=%0d", video_data, gmem[v_slot], cyc); end
                checks++; if (cyc - v_t0 < 4 || cyc - v_t0 > 8) begin failures++; $display("FAIL rnd_video_lat: got %0d want 4..8", cyc - v_t0); end
                v_pend = 1'b0; video_req = 1'b0; nv++;
            end else if (v_pend && cyc - v_t0 > 8) begin
                checks++; failures++; $display("FAIL rnd_video_timeout: got no ack after %0d cycles want <=8", cyc - v_t0);
                v_pend = 1'b0; video_req = 1'b0;
            end else if (!v_pend && cyc < 680 && $urandom_range(2) == 0) begin
                v_slot = 3'($urandom); video_addr = RBASE + 19'(v_slot);
                video_req = 1'b1; v_pend = 1'b1; v_t0 = cyc;
            end
            if (cpu_ack) begin
                if (c_we) gmem[c_slot] = c_wd;
                else begin
                    checks++; if (!c_pend || cpu_rdata !== gmem[c_slot]) begin failures++; $display("FAIL rnd_cpu_rd: got %h want %h cyc=%0d", cpu_rdata, gmem[c_slot], cyc); end
                end
                checks++; if (cyc - c_t0 < 4 || cyc - c_t0 > 8) begin failures++; $display("FAIL rnd_cpu_lat: got %0d want 4..8", cyc - c_t0); end
                c_pend = 1'b0; cpu_req = 1'b0; nc++;
            end else if (c_pend && cyc - c_t0 > 8) begin
                checks++; failures++; $display("FAIL rnd_cpu_timeout: got no ack after %0d cycles want <=8", cyc - c_t0);
                c_pend = 1'b0; cpu_req = 1'b0;
            end else if (!c_pend && cyc < 680 && $urandom_range(2) == 0) begin
                c_slot = 3'($urandom); c_we = 1'($urandom); c_wd = 8'($urandom);
                cpu_addr = RBASE + 19'(c_slot); cpu_we = c_we; cpu_wdata = c_wd;
                cpu_req = 1'b1; c_pend = 1'b1; c_t0 = cyc;
            end
        end
        checks++; if (nv < 20 || nc < 20) begin failures++; $display("FAIL rnd_activity: got v=%0d c=%0d want >=20 each", nv, nc); end
    endtask

    initial begin
        test_reset();
        test_video_only();
        test_cpu_write_read();
        test_first_simultaneous();
        test_contention();
        test_cpu_wait();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
